// File: rtl/viterbi_decode_core_pkg.sv
// Shared definitions for the K=3, rate-1/2 (7/5 octal) hard-decision Viterbi decoder.
// Holds the code constants, FSM encoding and the branch-metric helpers.
package viterbi_decode_core_pkg;

  localparam int NUM_STATES = 4;
  localparam int K          = 3;
  localparam int NUM_STEPS  = 8;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;
  localparam int PM_W       = 5;
  localparam logic [PM_W-1:0] PM_INIT = 5'd20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACS   = 2'd1,
    ST_TRACE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Encoder output {g0,g1} for input bit u leaving state s={u[t-1],u[t-2]}.
  function automatic logic [1:0] expected_pair(input logic u, input logic [1:0] s);
    logic [2:0] reg_bits;
    reg_bits = {u, s[1], s[0]};
    return {^(G0 & reg_bits), ^(G1 & reg_bits)};
  endfunction

  function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] ex);
    logic [1:0] diff;
    diff = rx ^ ex;
    return {diff[1] & diff[0], diff[1] ^ diff[0]};
  endfunction

endpackage

// File: rtl/viterbi_decode_core_acs.sv
// Add-compare-select for one next state n={u,a}; predecessors are {a,0} and {a,1}.
// Ties go to the even predecessor, so the survivor bit is the chosen predecessor LSB.
module viterbi_decode_core_acs
  import viterbi_decode_core_pkg::*;
#(
  parameter logic [1:0] NEXT_STATE = 2'b00
) (
  input  logic [1:0]      rx,
  input  logic [PM_W-1:0] pm_even,
  input  logic [PM_W-1:0] pm_odd,
  output logic [PM_W-1:0] new_metric,
  output logic            surv
);

  localparam logic [1:0] PRED_EVEN = {NEXT_STATE[0], 1'b0};
  localparam logic [1:0] PRED_ODD  = {NEXT_STATE[0], 1'b1};

  logic [1:0]    bm_even;
  logic [1:0]    bm_odd;
  logic [PM_W:0] sum_even;
  logic [PM_W:0] sum_odd;

  assign bm_even  = branch_metric(rx, expected_pair(NEXT_STATE[1], PRED_EVEN));
  assign bm_odd   = branch_metric(rx, expected_pair(NEXT_STATE[1], PRED_ODD));
  assign sum_even = {1'b0, pm_even} + {{(PM_W-1){1'b0}}, bm_even};
  assign sum_odd  = {1'b0, pm_odd}  + {{(PM_W-1){1'b0}}, bm_odd};

  // Metrics stay below 2^PM_W, so the carry bit of the sum can be dropped.
  always_comb begin
    if (sum_odd < sum_even) begin
      new_metric = sum_odd[PM_W-1:0];
      surv       = 1'b1;
    end else begin
      new_metric = sum_even[PM_W-1:0];
      surv       = 1'b0;
    end
  end

endmodule

// File: rtl/viterbi_decode_core.sv
// Viterbi decoder core: accepts a 16-bit packet of eight code pairs, runs 8 ACS steps,
// traces back 8 steps and reports the decoded byte, then pulses renew to the buffer.
module viterbi_decode_core
  import viterbi_decode_core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      bit_pair_0,
  input  logic [1:0]      bit_pair_1,
  input  logic [1:0]      bit_pair_2,
  input  logic [1:0]      bit_pair_3,
  input  logic [1:0]      bit_pair_4,
  input  logic [1:0]      bit_pair_5,
  input  logic [1:0]      bit_pair_6,
  input  logic [1:0]      bit_pair_7,
  output logic [7:0]      decoded_data,
  output logic [PM_W-1:0] path_metric,
  output logic            out_valid,
  output logic            renew,
  output logic            busy
);

  state_t          state_r;
  logic [2:0]      step_r;
  logic [15:0]     word_r;
  logic [15:0]     last_word_r;
  logic [PM_W-1:0] pm_r [NUM_STATES];
  logic [3:0]      surv_r [NUM_STEPS];
  logic [1:0]      trace_st_r;
  logic [7:0]      dec_r;
  logic [PM_W-1:0] best_metric_r;

  logic [15:0]     word_in;
  logic [1:0]      rx;
  logic [PM_W-1:0] new_pm [NUM_STATES];
  logic [3:0]      new_surv;
  logic [1:0]      best_idx;
  logic [PM_W-1:0] best_pm;
  logic [7:0]      dec_next;
  logic [1:0]      trace_prev;

  assign word_in = {bit_pair_7, bit_pair_6, bit_pair_5, bit_pair_4,
                    bit_pair_3, bit_pair_2, bit_pair_1, bit_pair_0};
  assign rx      = word_r[{step_r, 1'b0} +: 2];

  for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
    localparam logic [1:0] NS = 2'(g);
    viterbi_decode_core_acs #(.NEXT_STATE(NS)) u_acs (
      .rx         (rx),
      .pm_even    (pm_r[{NS[0], 1'b0}]),
      .pm_odd     (pm_r[{NS[0], 1'b1}]),
      .new_metric (new_pm[g]),
      .surv       (new_surv[g])
    );
  end

  // Final-state selection: smallest metric, ties to the lowest state index.
  always_comb begin
    best_idx = 2'd0;
    best_pm  = new_pm[0];
    for (int i = 1; i < NUM_STATES; i++) begin
      if (new_pm[i] < best_pm) begin
        best_idx = 2'(i);
        best_pm  = new_pm[i];
      end else begin
        best_pm  = best_pm;
      end
    end
  end

  // One traceback step: emit the state's MSB, walk to the stored predecessor.
  always_comb begin
    dec_next         = dec_r;
    dec_next[step_r] = trace_st_r[1];
    trace_prev       = {trace_st_r[0], surv_r[step_r][trace_st_r]};
  end

  // Decoder FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      step_r        <= 3'd0;
      word_r        <= 16'h0000;
      last_word_r   <= 16'h0000;
      trace_st_r    <= 2'd0;
      dec_r         <= 8'h00;
      best_metric_r <= '0;
      for (int i = 0; i < NUM_STATES; i++) pm_r[i] <= '0;
      for (int i = 0; i < NUM_STEPS; i++) surv_r[i] <= 4'h0;
      decoded_data  <= 8'h00;
      path_metric   <= '0;
      out_valid     <= 1'b0;
      renew         <= 1'b0;
      busy          <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      renew     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if ((word_in != 16'h0000) && (word_in != last_word_r)) begin
            word_r      <= word_in;
            last_word_r <= word_in;
            pm_r[0]     <= '0;
            pm_r[1]     <= PM_INIT;
            pm_r[2]     <= PM_INIT;
            pm_r[3]     <= PM_INIT;
            step_r      <= 3'd0;
            busy        <= 1'b1;
            state_r     <= ST_ACS;
          end else begin
            busy        <= 1'b0;
          end
        end
        ST_ACS: begin
          for (int i = 0; i < NUM_STATES; i++) pm_r[i] <= new_pm[i];
          surv_r[step_r] <= new_surv;
          if (step_r == 3'd7) begin
            trace_st_r    <= best_idx;
            best_metric_r <= best_pm;
            state_r       <= ST_TRACE;
          end else begin
            step_r        <= step_r + 3'd1;
          end
        end
        ST_TRACE: begin
          dec_r      <= dec_next;
          trace_st_r <= trace_prev;
          if (step_r == 3'd0) begin
            decoded_data <= dec_next;
            path_metric  <= best_metric_r;
            out_valid    <= 1'b1;
            renew        <= 1'b1;
            state_r      <= ST_DONE;
          end else begin
            step_r       <= step_r - 3'd1;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
